alu_cmd_sequencer: RTL

Command-side controller that drives the 16-bit ALU. It accepts register-level commands over a valid/ready handshake and reads operands from a local 4-entry register file. It presents operands and opcode to the ALU, holds them for the ALU latency, then captures result and flags. It writes the result back to the register file and returns it over a valid/ready response channel.

---
 rtl/alu_cmd_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//
// Command-side controller for a 16-bit ALU. Commands arrive over a
// valid/ready handshake and name registers in a local 4-entry register file.
// The sequencer presents the operands and the opcode to the ALU and holds
// them for ALU_LAT+1 cycles. It then captures the result and flags, writes
// the result back to R[rd] and returns it over a valid/ready response
// channel. Opcode 15 (LDI) never reaches the ALU: the immediate is written
// straight into R[rd] and returned.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_valid/ready     command handshake
//   cmd_op              ALU opcode 0..14, 15 = LDI
//   cmd_rd/ra/rb        destination and operand register indices
//   cmd_use_imm         operand B taken from cmd_imm instead of R[rb]
//   cmd_imm             immediate value
//   alu_a/alu_b/alu_op  operands and opcode presented to the ALU
//   alu_result/zero/ovf result and flags returned by the ALU
//   rsp_valid/ready     response handshake
//   rsp_data/zero/ovf   result written to R[rd] and its flags
//   dbg_sel/dbg_data    combinational debug read of the register file

module alu_cmd_sequencer #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_ra,
  input  logic [1:0]       cmd_rb,
  input  logic             cmd_use_imm,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDI   = 4'hF;
  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] regs [4];
  logic [1:0]       rd_q;
  logic [2:0]       cnt;
  logic             accept;

  // State register. Reset always lands in IDLE, which also drops any
  // operation in flight so that no writeback happens for it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. LDI skips EXEC entirely since the ALU is not involved.
  // EXEC lasts until the wait counter reaches zero, i.e. ALU_LAT+1 cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (cmd_op == OP_LDI) ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (cnt == 3'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend only on the state. Commands are accepted only
  // in IDLE, so cmd_valid is ignored everywhere else.
  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    accept    = cmd_valid && (state == IDLE);
  end

  // Datapath. Operands are read from the register file at acceptance. This
  // is what makes rd == ra or rd == rb use the old value, and it removes any
  // read-after-write hazard between consecutive commands. The alu_* outputs
  // are only reloaded by ALU commands and otherwise keep their last values.
  // The response registers are loaded once per command and then hold
  // through any backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
      rd_q     <= '0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        rd_q <= cmd_rd;
        if (cmd_op == OP_LDI) begin
          regs[cmd_rd] <= cmd_imm;
          rsp_data     <= cmd_imm;
          rsp_zero     <= (cmd_imm == '0);
          rsp_ovf      <= 1'b0;
        end else begin
          alu_a  <= regs[cmd_ra];
          alu_b  <= cmd_use_imm ? cmd_imm : regs[cmd_rb];
          alu_op <= cmd_op;
          cnt    <= LAT_INIT;
        end
      end

      if (state == EXEC) begin
        if (cnt == 3'd0) begin
          rsp_data   <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_ovf    <= alu_ovf;
          regs[rd_q] <= alu_result;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end
    end
  end

  // Debug read port: an unregistered view of the register file.
  assign dbg_data = regs[dbg_sel];

endmodule
